execute_shift_rotate: RTL and testbench

EXECUTE_SHIFT_ROTATE -- requirements
Module: execute_shift_rotate

---
 rtl/execute_shift_rotate.sv | 190 +++++++++++++++++++
 tb/tb_execute_shift_rotate.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/execute_shift_rotate.sv
// Iterative x86-style shift/rotate unit. It performs one 1-bit step per cycle,
// then presents the result together with its CF/OF flag values.
module execute_shift_rotate #(
  parameter int BIT_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           op,
  input  logic [BIT_WIDTH-1:0] operand,
  input  logic [4:0]           count,
  input  logic                 carry_in,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] result,
  output logic                 carry_out,
  output logic                 overflow_out,
  output logic                 flags_update
);

  localparam int MSB = BIT_WIDTH - 1;

  localparam logic [2:0] OP_ROL = 3'd0;
  localparam logic [2:0] OP_ROR = 3'd1;
  localparam logic [2:0] OP_RCL = 3'd2;
  localparam logic [2:0] OP_RCR = 3'd3;
  localparam logic [2:0] OP_SHL = 3'd4;
  localparam logic [2:0] OP_SHR = 3'd5;
  localparam logic [2:0] OP_SAL = 3'd6;
  localparam logic [2:0] OP_SAR = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Rotates wrap at the rotation period; RCL/RCR include CF, so the period is one bit longer.
  function automatic logic [4:0] eff_count(input logic [2:0] o, input logic [4:0] c);
    logic [5:0] c6;
    c6 = {1'b0, c};
    case (o)
      OP_ROL, OP_ROR: eff_count = 5'(c6 % 6'(BIT_WIDTH));
      OP_RCL, OP_RCR: eff_count = 5'(c6 % 6'(BIT_WIDTH + 1));
      default:        eff_count = c;
    endcase
  endfunction

  // One 1-bit step; the return value is {new_cf, new_value}.
  function automatic logic [BIT_WIDTH:0] step_once(input logic [2:0] o,
                                                   input logic [BIT_WIDTH-1:0] v,
                                                   input logic cf);
    case (o)
      OP_ROL:         step_once = {v[MSB], v[MSB-1:0], v[MSB]};
      OP_ROR:         step_once = {v[0], v[0], v[MSB:1]};
      OP_RCL:         step_once = {v[MSB], v[MSB-1:0], cf};
      OP_RCR:         step_once = {v[0], cf, v[MSB:1]};
      OP_SHL, OP_SAL: step_once = {v[MSB], v[MSB-1:0], 1'b0};
      OP_SHR:         step_once = {v[0], 1'b0, v[MSB:1]};
      OP_SAR:         step_once = {v[0], v[MSB], v[MSB:1]};
      default:        step_once = {cf, v};
    endcase
  endfunction

  state_t               state_r;
  logic [2:0]           op_r;
  logic [BIT_WIDTH-1:0] value_r;
  logic                 cf_r;
  logic                 cin_r;
  logic                 op_msb_r;
  logic                 zero_cnt_r;
  logic [4:0]           cnt_r;
  logic                 out_valid_r;
  logic [BIT_WIDTH-1:0] result_r;
  logic                 carry_out_r;
  logic                 overflow_out_r;
  logic                 flags_update_r;

  logic [4:0]           n_s;
  logic [BIT_WIDTH:0]   step_s;
  logic                 fin_cf_s;
  logic                 fin_of_s;

  assign n_s    = eff_count(op, count);
  assign step_s = step_once(op_r, value_r, cf_r);

  // Final CF/OF from the completed working value. A count of zero leaves the flags untouched.
  always_comb begin
    fin_cf_s = cf_r;
    fin_of_s = 1'b0;
    if (zero_cnt_r) begin
      fin_cf_s = cin_r;
      fin_of_s = 1'b0;
    end else begin
      case (op_r)
        OP_ROL: begin
          fin_cf_s = value_r[0];
          fin_of_s = value_r[MSB] ^ value_r[0];
        end
        OP_ROR: begin
          fin_cf_s = value_r[MSB];
          fin_of_s = value_r[MSB] ^ value_r[MSB-1];
        end
        OP_RCL, OP_SHL, OP_SAL: fin_of_s = value_r[MSB] ^ cf_r;
        OP_RCR:                 fin_of_s = op_msb_r ^ cin_r;
        OP_SHR:                 fin_of_s = op_msb_r;
        OP_SAR:                 fin_of_s = 1'b0;
        default:                fin_of_s = 1'b0;
      endcase
    end
  end

  // Control FSM, working registers and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= IDLE;
      op_r           <= 3'd0;
      value_r        <= '0;
      cf_r           <= 1'b0;
      cin_r          <= 1'b0;
      op_msb_r       <= 1'b0;
      zero_cnt_r     <= 1'b0;
      cnt_r          <= 5'd0;
      out_valid_r    <= 1'b0;
      result_r       <= '0;
      carry_out_r    <= 1'b0;
      overflow_out_r <= 1'b0;
      flags_update_r <= 1'b0;
    end else if (flush) begin
      state_r     <= IDLE;
      cnt_r       <= 5'd0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            op_r       <= op;
            value_r    <= operand;
            cf_r       <= carry_in;
            cin_r      <= carry_in;
            op_msb_r   <= operand[MSB];
            zero_cnt_r <= (count == 5'd0);
            cnt_r      <= n_s;
            state_r    <= (n_s == 5'd0) ? DONE : SHIFT;
          end else begin
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          {cf_r, value_r} <= step_s;
          cnt_r           <= cnt_r - 5'd1;
          if (cnt_r == 5'd1) begin
            state_r <= DONE;
          end else begin
            state_r <= SHIFT;
          end
        end
        DONE: begin
          // The first DONE cycle publishes the result; it is then held until consumed.
          if (!out_valid_r) begin
            result_r       <= value_r;
            carry_out_r    <= fin_cf_s;
            overflow_out_r <= fin_of_s;
            flags_update_r <= !zero_cnt_r;
            out_valid_r    <= 1'b1;
          end else if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = (state_r == IDLE);
  assign out_valid    = out_valid_r;
  assign result       = result_r;
  assign carry_out    = carry_out_r;
  assign overflow_out = overflow_out_r;
  assign flags_update = flags_update_r;

endmodule

// File: tb/tb_execute_shift_rotate.sv
// Directed bench for execute_shift_rotate. Three instances (8/16/32-bit) share stimulus;
// in_valid selects the instance under test.
module tb_execute_shift_rotate;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        out_ready;
  logic        carry_in;
  logic [2:0]  op;
  logic [4:0]  count;
  logic [31:0] operand;
  logic [2:0]  in_valid;
  logic [2:0]  in_ready;
  logic [2:0]  out_valid;
  logic [2:0]  carry_out;
  logic [2:0]  overflow_out;
  logic [2:0]  flags_update;
  logic [7:0]  r8;
  logic [15:0] r16;
  logic [31:0] r32;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  execute_shift_rotate #(.BIT_WIDTH(8)) u_w8 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .op(op), .operand(operand[7:0]), .count(count), .carry_in(carry_in), .flush(flush),
    .out_valid(out_valid[0]), .out_ready(out_ready), .result(r8), .carry_out(carry_out[0]),
    .overflow_out(overflow_out[0]), .flags_update(flags_update[0]));

  execute_shift_rotate #(.BIT_WIDTH(16)) u_w16 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .op(op), .operand(operand[15:0]), .count(count), .carry_in(carry_in), .flush(flush),
    .out_valid(out_valid[1]), .out_ready(out_ready), .result(r16), .carry_out(carry_out[1]),
    .overflow_out(overflow_out[1]), .flags_update(flags_update[1]));

  execute_shift_rotate #(.BIT_WIDTH(32)) u_w32 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .op(op), .operand(operand), .count(count), .carry_in(carry_in), .flush(flush),
    .out_valid(out_valid[2]), .out_ready(out_ready), .result(r32), .carry_out(carry_out[2]),
    .overflow_out(overflow_out[2]), .flags_update(flags_update[2]));

  function automatic logic [31:0] res(input int sel);
    case (sel)
      0:       res = {24'd0, r8};
      1:       res = {16'd0, r16};
      default: res = r32;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request, measure latency, check outputs (optionally stalling out_ready), then consume.
  task automatic run_op(input string tag, input int sel, input logic [2:0] o,
                        input logic [31:0] v, input logic [4:0] c, input logic ci,
                        input logic [31:0] er, input logic ecf, input logic eof,
                        input logic efu, input int elat, input int stall);
    int lat = 0;
    bit got = 1'b0;
    @(negedge clock);
    check_eq({tag, ".in_ready"}, 32'(in_ready[sel]), 32'd1);
    op = o; operand = v; count = c; carry_in = ci;
    in_valid = 3'(1 << sel);
    @(posedge clock);
    #1;
    in_valid = 3'b000;
    op = ~o; operand = ~v; count = ~c; carry_in = ~ci;
    while (!got && lat < 100) begin
      @(posedge clock);
      lat++;
      #1;
      if (out_valid[sel]) got = 1'b1;
    end
    check_eq({tag, ".latency"}, got ? 32'(lat) : 32'hFFFF_FFFF, 32'(elat));
    check_eq({tag, ".result"}, res(sel), er);
    check_eq({tag, ".carry_out"}, 32'(carry_out[sel]), 32'(ecf));
    check_eq({tag, ".overflow_out"}, 32'(overflow_out[sel]), 32'(eof));
    check_eq({tag, ".flags_update"}, 32'(flags_update[sel]), 32'(efu));
    for (int i = 0; i < stall; i++) begin
      @(negedge clock);
      in_valid = 3'(1 << sel);
      check_eq({tag, ".stall_valid"}, 32'(out_valid[sel]), 32'd1);
      check_eq({tag, ".stall_in_ready"}, 32'(in_ready[sel]), 32'd0);
      check_eq({tag, ".stall_result"}, res(sel), er);
      check_eq({tag, ".stall_cf"}, 32'(carry_out[sel]), 32'(ecf));
    end
    @(negedge clock);
    in_valid  = 3'b000;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    check_eq({tag, ".idle_in_ready"}, 32'(in_ready[sel]), 32'd1);
    check_eq({tag, ".idle_out_valid"}, 32'(out_valid[sel]), 32'd0);
  endtask

  // Start a 20-step SHR on the 8-bit instance and return just after the accept edge.
  task automatic start_long_shr();
    @(negedge clock);
    op = 3'd5; operand = 32'hFF; count = 5'd20; carry_in = 1'b0;
    in_valid = 3'b001;
    @(posedge clock);
    #1;
    in_valid = 3'b000;
  endtask

  task automatic expect_no_valid(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (out_valid[0]) seen = 1'b1;
    end
    check_eq(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; out_ready = 1'b0; carry_in = 1'b0;
    op = 3'd0; count = 5'd0; operand = 32'd0; in_valid = 3'b000;
    #1;
    check_eq("rst.in_ready", 32'(in_ready), 32'h7);
    check_eq("rst.out_valid", 32'(out_valid), 32'h0);
    check_eq("rst.result32", r32, 32'h0);
    check_eq("rst.flags", {29'd0, flags_update}, 32'h0);
    check_eq("rst.cf_of", {26'd0, carry_out, overflow_out}, 32'h0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    //     tag          sel op    operand        cnt    cin   result         cf    of    fu    lat stall
    run_op("rol_1",      0, 3'd0, 32'h81,        5'd1,  1'b0, 32'h03,        1'b1, 1'b1, 1'b1, 2,  0);
    run_op("rcr_9",      0, 3'd3, 32'h01,        5'd9,  1'b1, 32'h01,        1'b1, 1'b1, 1'b1, 1,  0);
    run_op("sar32_31",   2, 3'd7, 32'h80000000,  5'd31, 1'b0, 32'hFFFFFFFF,  1'b0, 1'b0, 1'b1, 32, 0);
    run_op("shl16_0",    1, 3'd4, 32'h1234,      5'd0,  1'b1, 32'h1234,      1'b1, 1'b0, 1'b0, 1,  0);
    run_op("ror_1",      0, 3'd1, 32'h01,        5'd1,  1'b0, 32'h80,        1'b1, 1'b1, 1'b1, 2,  0);
    run_op("rcl_1",      0, 3'd2, 32'h80,        5'd1,  1'b0, 32'h00,        1'b1, 1'b1, 1'b1, 2,  0);
    run_op("shr_1",      0, 3'd5, 32'h81,        5'd1,  1'b0, 32'h40,        1'b1, 1'b1, 1'b1, 2,  0);
    run_op("shl_2",      0, 3'd4, 32'h40,        5'd2,  1'b0, 32'h00,        1'b1, 1'b1, 1'b1, 3,  0);
    run_op("shr_20",     0, 3'd5, 32'hFF,        5'd20, 1'b0, 32'h00,        1'b0, 1'b1, 1'b1, 21, 0);
    run_op("sar_10",     0, 3'd7, 32'h80,        5'd10, 1'b0, 32'hFF,        1'b1, 1'b0, 1'b1, 11, 0);
    run_op("rol_8",      0, 3'd0, 32'h81,        5'd8,  1'b0, 32'h81,        1'b1, 1'b0, 1'b1, 1,  0);
    run_op("ror_4",      0, 3'd1, 32'h12,        5'd4,  1'b1, 32'h21,        1'b0, 1'b0, 1'b1, 5,  0);
    run_op("rcl_9",      0, 3'd2, 32'h00,        5'd9,  1'b1, 32'h00,        1'b1, 1'b1, 1'b1, 1,  0);
    run_op("rcr_1",      0, 3'd3, 32'h80,        5'd1,  1'b0, 32'h40,        1'b0, 1'b1, 1'b1, 2,  0);
    run_op("sal_1",      0, 3'd6, 32'hC0,        5'd1,  1'b0, 32'h80,        1'b1, 1'b0, 1'b1, 2,  0);
    run_op("sar_1",      0, 3'd7, 32'h7F,        5'd1,  1'b0, 32'h3F,        1'b1, 1'b0, 1'b1, 2,  0);
    run_op("stall_rol",  0, 3'd0, 32'h81,        5'd1,  1'b0, 32'h03,        1'b1, 1'b1, 1'b1, 2,  5);

    // Flush on the third cycle of a 20-step SHR.
    start_long_shr();
    repeat (2) @(posedge clock);
    @(negedge clock);
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    check_eq("flush.in_ready", 32'(in_ready[0]), 32'd1);
    check_eq("flush.out_valid", 32'(out_valid[0]), 32'd0);
    expect_no_valid("flush.no_valid");

    // Asynchronous reset in the middle of the same long SHR.
    start_long_shr();
    repeat (4) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_eq("arst.in_ready", 32'(in_ready[0]), 32'd1);
    check_eq("arst.out_valid", 32'(out_valid[0]), 32'd0);
    check_eq("arst.result", res(0), 32'h0);
    check_eq("arst.flags", 32'(flags_update[0]), 32'd0);
    check_eq("arst.cf", 32'(carry_out[0]), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    expect_no_valid("arst.no_valid");

    run_op("post_rst",   0, 3'd0, 32'h81,        5'd1,  1'b0, 32'h03,        1'b1, 1'b1, 1'b1, 2,  0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
